// File: rtl/byte_stream_scrambler.sv
// Transmit-side byte scrambler: XORs accepted bytes with an 8-bit LFSR keystream
// and queues the result in a 2-entry output buffer with valid/ready on both sides.
module byte_stream_scrambler #(
  parameter logic [7:0]  SEED  = 8'hFF,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [7:0]       din,
  input  logic             din_valid,
  input  logic             din_sof,
  output logic             din_ready,
  output logic [7:0]       dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [7:0]       lfsr,
  output logic [CNT_W-1:0] byte_count
);

  if (SEED == 8'h00) begin : g_seed_check
    $error("byte_stream_scrambler: SEED must be nonzero");
  end

  typedef enum logic [1:0] {EMPTY, ONE, FULL} occ_t;

  occ_t       state, state_next;
  logic [7:0] tail;
  logic [7:0] key;
  logic [7:0] scrambled;
  logic       accept;
  logic       pop;

  assign accept    = din_valid & din_ready;
  assign pop       = dout_valid & dout_ready;
  assign key       = din_sof ? SEED : lfsr;
  assign scrambled = din ^ key;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= EMPTY;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      EMPTY: if (accept) state_next = ONE;
      ONE: begin
        if (accept && !pop)      state_next = FULL;
        else if (!accept && pop) state_next = EMPTY;
      end
      FULL:    if (pop) state_next = ONE;
      default: state_next = EMPTY;
    endcase
  end

  // Ready depends only on registered occupancy, never on dout_ready.
  always_comb begin
    din_ready  = 1'b0;
    dout_valid = 1'b0;
    din_ready  = enable & ~reset & (state != FULL);
    dout_valid = (state != EMPTY);
  end

  // dout is the head register; it keeps its last value when the buffer empties.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dout <= '0;
      tail <= '0;
    end else begin
      unique case (state)
        EMPTY: if (accept) dout <= scrambled;
        ONE: begin
          if (accept && pop) dout <= scrambled;
          else if (accept)   tail <= scrambled;
        end
        FULL:    if (pop) dout <= tail;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lfsr       <= SEED;
      byte_count <= '0;
    end else if (accept) begin
      lfsr <= {key[6:0], key[6] ^ key[3]};
      if (din_sof)          byte_count <= CNT_W'(1);
      else if (!(&byte_count)) byte_count <= byte_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_byte_stream_scrambler.sv
// Randomized self-checking bench for byte_stream_scrambler against a queue-based
// model of the keystream and output buffer, plus directed literal checks.
module tb_byte_stream_scrambler;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [7:0]  din = '0;
  logic        din_valid = 1'b0;
  logic        din_sof = 1'b0;
  logic        dout_ready = 1'b0;
  logic        din_ready, dout_valid;
  logic [7:0]  dout, lfsr;
  logic [15:0] byte_count;
  logic        din_ready_s, dout_valid_s;
  logic [7:0]  dout_s, lfsr_s;
  logic [2:0]  byte_count_s;

  byte_stream_scrambler #(.SEED(8'hFF), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .enable(enable), .din(din), .din_valid(din_valid),
    .din_sof(din_sof), .din_ready(din_ready), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .lfsr(lfsr), .byte_count(byte_count));

  byte_stream_scrambler #(.SEED(8'hFF), .CNT_W(3)) dut_small (
    .clock(clock), .reset(reset), .enable(enable), .din(din), .din_valid(din_valid),
    .din_sof(din_sof), .din_ready(din_ready_s), .dout(dout_s), .dout_valid(dout_valid_s),
    .dout_ready(dout_ready), .lfsr(lfsr_s), .byte_count(byte_count_s));

  always #5 clock = ~clock;

  int unsigned total = 0;
  int unsigned bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: keystream position in frame, FIFO contents, last value shown on dout.
  logic [7:0] ks [0:2047];
  logic [7:0] q [$];
  logic [7:0] last_out;
  int unsigned p;
  logic [7:0] dut_log [$];
  logic [8:0] in_log [$];
  bit rnd_mode = 0;

  function automatic logic [7:0] ks_at(input int unsigned i);
    return (i < 2048) ? ks[i] : 8'h00;
  endfunction

  initial begin
    logic [7:0] k;
    ks[0] = 8'hFF;
    for (int i = 1; i < 2048; i++) begin
      k = ks[i-1];
      ks[i] = {k[6:0], k[6] ^ k[3]};
    end
    last_out = '0;
    p = 0;
  end

  always @(posedge clock) begin
    bit acc, pp;
    if (!reset) begin
      acc = din_valid && enable && (q.size() < 2);
      pp  = (q.size() != 0) && dout_ready;
      if (pp) begin
        last_out = q[0];
        void'(q.pop_front());
      end
      if (acc) begin
        if (din_sof) p = 0;
        q.push_back(din ^ ks_at(p));
        p = p + 1;
        in_log.push_back({din_sof, din});
      end
    end
  end

  always @(negedge clock) begin
    logic [7:0] exp_dout;
    if (reset) begin
      q.delete();
      p = 0;
      last_out = '0;
    end
    exp_dout = (q.size() != 0) ? q[0] : last_out;
    chk("din_ready", din_ready, !reset && enable && (q.size() < 2));
    chk("dout_valid", dout_valid, q.size() != 0);
    chk("dout", dout, exp_dout);
    chk("lfsr", lfsr, ks_at(p));
    chk("byte_count", byte_count, p > 65535 ? 65535 : p);
    chk("byte_count_sat", byte_count_s, p > 7 ? 7 : p);
    chk("dout_small", dout_s, exp_dout);
    chk("dout_valid_small", dout_valid_s, q.size() != 0);
    chk("din_ready_small", din_ready_s, !reset && enable && (q.size() < 2));
    if (!reset && dout_valid && dout_ready) dut_log.push_back(dout);
  end

  always @(posedge clock) begin
    if (rnd_mode) begin
      #1;
      dout_ready = ($urandom_range(0, 3) != 0);
      enable     = ($urandom_range(0, 7) != 0);
    end
  end

  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    dut_log.delete();
    in_log.delete();
  endtask

  task automatic send(input logic [7:0] d, input logic s);
    int unsigned n;
    logic r;
    din = d;
    din_sof = s;
    din_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clock);
      r = din_ready;
      @(posedge clock);
      #1;
      n++;
      if (r) break;
      if (n >= 50) begin
        total++;
        bad++;
        $display("FAIL send_timeout: got no accept within %0d cycles", n);
        break;
      end
    end
    din_valid = 1'b0;
    din_sof = 1'b0;
  endtask

  logic [7:0] ref8 [0:7];

  initial begin
    int unsigned pos;
    logic [8:0] e;
    logic s;
    ref8[0] = 8'hFF; ref8[1] = 8'hFE; ref8[2] = 8'hFC; ref8[3] = 8'hF8;
    ref8[4] = 8'hF0; ref8[5] = 8'hE1; ref8[6] = 8'hC3; ref8[7] = 8'h87;
    for (int i = 0; i < 8; i++) chk("model_keystream", ks[i], ref8[i]);

    // 6 back-to-back 00 bytes.
    enable = 1'b1; dout_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 6; i++) send(8'h00, 1'b0);
    idle(2);
    for (int i = 0; i < 6; i++) chk("seq6_dout", dut_log[i], ref8[i]);
    chk("seq6_lfsr", lfsr, 8'hC3);
    chk("seq6_count", byte_count, 6);

    // Single sof byte.
    do_reset();
    send(8'hA5, 1'b1);
    idle(2);
    chk("sof_dout", dut_log[0], 8'h5A);
    chk("sof_lfsr", lfsr, 8'hFE);
    chk("sof_count", byte_count, 1);

    // sof mid-stream reseeds.
    do_reset();
    for (int i = 0; i < 3; i++) send(8'h00, 1'b0);
    send(8'h00, 1'b1);
    idle(2);
    chk("reseed_d0", dut_log[0], 8'hFF);
    chk("reseed_d1", dut_log[1], 8'hFE);
    chk("reseed_d2", dut_log[2], 8'hFC);
    chk("reseed_d3", dut_log[3], 8'hFF);
    chk("reseed_count", byte_count, 1);

    // Backpressure: buffer fills, then drains in order.
    do_reset();
    dout_ready = 1'b0;
    din = 8'h00; din_valid = 1'b1;
    idle(4);
    chk("full_ready", din_ready, 0);
    chk("full_lfsr", lfsr, 8'hFC);
    dout_ready = 1'b1;
    idle(4);
    din_valid = 1'b0;
    idle(3);
    chk("drain_size", dut_log.size(), in_log.size());
    for (int i = 0; i < 4; i++) chk("drain_order", dut_log[i], ref8[i]);

    // Enable gap does not skip keystream values.
    do_reset();
    din = 8'h00; din_valid = 1'b1;
    idle(3);
    enable = 1'b0;
    idle(3);
    enable = 1'b1;
    idle(5);
    din_valid = 1'b0;
    idle(3);
    for (int i = 0; i < 8; i++) chk("gap_dout", dut_log[i], ref8[i]);
    chk("gap_lfsr", lfsr, 8'h0E);
    chk("gap_count", byte_count, 8);

    // Reset with two bytes buffered.
    do_reset();
    dout_ready = 1'b0;
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    reset = 1'b1;
    #1;
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_din_ready", din_ready, 0);
    idle(2);
    reset = 1'b0;
    dout_ready = 1'b1;
    dut_log.delete();
    in_log.delete();
    send(8'h00, 1'b0);
    idle(2);
    chk("rst_first", dut_log[0], 8'hFF);

    // Random loopback through a bench-side descrambler.
    do_reset();
    rnd_mode = 1;
    for (int i = 0; i < 256; i++) begin
      s = (i == 0) || ($urandom_range(0, 31) == 0);
      send(8'($urandom_range(0, 255)), s);
      idle($urandom_range(0, 2));
    end
    rnd_mode = 0;
    @(posedge clock);
    #2;
    enable = 1'b1;
    dout_ready = 1'b1;
    idle(6);
    chk("loop_size", dut_log.size(), 256);
    chk("loop_in_size", in_log.size(), 256);
    pos = 0;
    for (int i = 0; i < 256; i++) begin
      e = in_log[i];
      if (e[8]) pos = 0;
      chk("loopback", dut_log[i] ^ ks_at(pos), e[7:0]);
      pos++;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/byte_stream_scrambler.md
Name: byte_stream_scrambler

Overview:
- Transmit-side partner of the team's byte descrambler.
- XORs each accepted input byte with an 8-bit LFSR keystream. The keystream starts at SEED and advances once per accepted byte, so the descrambler recovers the data when both ends start from the same seed.
- Sits between the framer and the serializer.
- Valid/ready on both sides, with a 2-entry output buffer so the upstream source is not stalled when the output is ready.

Parameters:
- SEED, 8'hFF, LFSR value used after reset and on every start of frame. Must be nonzero; 8'h00 locks the LFSR and is rejected by an elaboration check.
- CNT_W, 16, width of byte_count.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  when low, no new bytes are accepted; the output buffer still drains.
- din  input  8  plaintext byte.
- din_valid  input  1  din is valid.
- din_sof  input  1  start of frame, qualified by din_valid; reseeds the keystream for this byte.
- din_ready  output  1  scrambler can accept a byte this cycle.
- dout  output  8  scrambled byte.
- dout_valid  output  1  dout is valid.
- dout_ready  input  1  downstream accepts dout.
- lfsr  output  8  keystream state to be applied to the next accepted byte.
- byte_count  output  CNT_W  bytes accepted since the last reset or start of frame.

Behaviour:
- Reset values (asynchronous on reset high): lfsr = SEED, dout = 0, dout_valid = 0, buffer empty, din_ready = 0 while reset is high, byte_count = 0.
- Accept: accept = din_valid & din_ready.
- din_ready: enable & (buffer occupancy < 2). Computed from registered occupancy only, with no combinational path from dout_ready.
- Keystream, with K the key used for the accepted byte:
  - K = SEED if din_sof, else lfsr.
  - The byte pushed into the buffer is din ^ K.
  - lfsr next = {K[6:0], K[6]^K[3]}.
- When no byte is accepted, lfsr holds.
- Reference sequence from 8'hFF: FF, FE, FC, F8, F0, E1, C3, 87, ...
- Latency: a byte accepted in cycle N appears on dout with dout_valid = 1 in cycle N+1, provided no older entry is pending.
- Output buffer: 2-entry FIFO with order preserved.
  - dout/dout_valid always present the head entry.
  - Pop on dout_valid & dout_ready.
  - Push and pop in the same cycle is legal at occupancy 1 and leaves occupancy unchanged.
  - Full (2 entries): din_ready = 0.
  - Empty: dout_valid = 0 and dout holds its last value.
- byte_count:
  - Increments on accept and saturates at all-ones.
  - An accept with din_sof sets it to 1.
- din_sof without din_valid: ignored.
- din_valid while din_ready = 0: the byte is not consumed and lfsr is unchanged; the source must hold din, din_valid and din_sof.
- enable deasserted mid-stream: lfsr and byte_count hold; buffered bytes still drain.
- Reset mid-operation: buffered bytes are discarded, lfsr returns to SEED, byte_count returns to 0. No partial output is produced.
- dout_valid, once asserted, stays high with dout stable until popped.

Test Plan:
- Reset, enable = 1, dout_ready = 1, din = 00 for 6 consecutive accepts -> dout = FF, FE, FC, F8, F0, E1 one cycle after each accept; byte_count = 6; lfsr = C3.
- Reset, din = A5 accepted with din_sof = 1 -> dout = 5A one cycle later; lfsr = FE; byte_count = 1.
- Accept 00 three times, then 00 with din_sof = 1 -> outputs FF, FE, FC, FF; byte_count goes to 1 on the sof byte.
- dout_ready = 0 with continuous din_valid -> two bytes accepted, then din_ready = 0 and lfsr frozen. Raise dout_ready -> bytes drain in order with no loss or duplication.
- Toggle enable low for 3 cycles in a 00 stream -> din_ready = 0 during those cycles; the keystream resumes exactly where it stopped (no skipped values).
- Assert reset while 2 entries are buffered -> dout_valid = 0 immediately; after release the first accepted 00 yields FF.
- Loopback into the descrambler from the same reset, random 256 bytes -> recovered data equals input.
